// File: rtl/rf_pkg.sv
// Shared types and helpers for the banked register file: clear-sequencer
// state encoding and the log2 used to size the global and per-bank addresses.
package rf_pkg;

   typedef enum logic [0:0] {
      CLR_IDLE  = 1'b0,
      CLR_SWEEP = 1'b1
   } clr_state_t;

   // Number of address bits needed to index 'value' entries (ceiling log2).
   function automatic int clog2_f(input int value);
      int bits_v;
      bits_v = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            bits_v = i + 1;
         end else begin
            bits_v = bits_v;
         end
      end
      return bits_v;
   endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Sequential clear sweep: on a request while idle, walks an index over every
// entry, one per cycle, flagging each one for zeroing. Requests during a sweep
// are ignored, so a sweep always lasts exactly DEPTH cycles.
module rf_clear_seq
   import rf_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_en,
   output logic [AW-1:0] clr_idx
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   clr_state_t    state_r;
   logic [AW-1:0] cnt_r;
   logic          busy_r;

   // Sweep FSM with registered busy flag and sweep index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= CLR_IDLE;
         cnt_r   <= '0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            CLR_IDLE: begin
               if (clr_req) begin
                  state_r <= CLR_SWEEP;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= CLR_IDLE;
                  cnt_r   <= '0;
                  busy_r  <= 1'b0;
               end
            end
            CLR_SWEEP: begin
               if (cnt_r == LAST_IDX) begin
                  state_r <= CLR_IDLE;
                  cnt_r   <= '0;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r   <= cnt_r + AW'(1);
               end
            end
            default: begin
               state_r <= CLR_IDLE;
               cnt_r   <= '0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy = busy_r;
   assign clr_en   = busy_r;
   assign clr_idx  = cnt_r;

endmodule

// File: rtl/rf_banked_param.sv
// Banked register file: one write port per bank of contiguous entries, a
// single global read port (combinational or registered) with optional
// same-cycle write forwarding, and a sequential clear sweep that blocks writes.
module rf_banked_param
   import rf_pkg::*;
#(
   parameter  int DATA_W     = 8,
   parameter  int DEPTH      = 16,
   parameter  int N_WR       = 2,
   parameter  int REG_RD     = 0,
   parameter  int BYPASS     = 1,
   localparam int AW         = clog2_f(DEPTH),
   localparam int BANK_DEPTH = DEPTH / N_WR,
   localparam int BANK_AW    = clog2_f(BANK_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_WR-1:0]           wr_en,
   input  logic [N_WR*BANK_AW-1:0]   wr_addr,
   input  logic [N_WR*DATA_W-1:0]    data_in,
   input  logic [AW-1:0]             rd_addr,
   output logic [DATA_W-1:0]         data_out,
   output logic                      rd_valid,
   input  logic                      clr_req,
   output logic                      clr_busy
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0]  vld_r;

   logic              clr_busy_s;
   logic              clr_en_s;
   logic [AW-1:0]     clr_idx_s;

   logic [N_WR-1:0]   wr_acc_s;
   logic [AW-1:0]     wr_gaddr_s [N_WR];
   logic [N_WR-1:0]   byp_hit_s;
   logic              byp_any_s;
   logic [DATA_W-1:0] byp_data_s;
   logic [DATA_W-1:0] rd_data_s;
   logic              rd_vld_s;

   rf_clear_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy_s),
      .clr_en   (clr_en_s),
      .clr_idx  (clr_idx_s)
   );

   assign clr_busy = clr_busy_s;

   // Bank decode: each port lands in its own bank; writes are dropped while sweeping.
   always_comb begin
      for (int b = 0; b < N_WR; b++) begin
         wr_acc_s[b]   = wr_en[b] & ~clr_busy_s;
         wr_gaddr_s[b] = AW'(b * BANK_DEPTH) + AW'(wr_addr[b*BANK_AW +: BANK_AW]);
      end
   end

   // Storage and valid bits; the sweep and accepted writes never overlap in time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         vld_r <= '0;
      end else begin
         if (clr_en_s) begin
            mem_r[clr_idx_s] <= '0;
            vld_r[clr_idx_s] <= 1'b0;
         end
         for (int b = 0; b < N_WR; b++) begin
            if (wr_acc_s[b]) begin
               mem_r[wr_gaddr_s[b]] <= data_in[b*DATA_W +: DATA_W];
               vld_r[wr_gaddr_s[b]] <= 1'b1;
            end
         end
      end
   end

   // Read mux with forwarding; banks are disjoint so at most one port can hit.
   always_comb begin
      byp_any_s  = 1'b0;
      byp_data_s = '0;
      for (int b = 0; b < N_WR; b++) begin
         byp_hit_s[b] = wr_acc_s[b] && (wr_gaddr_s[b] == rd_addr);
         byp_any_s    = byp_any_s | byp_hit_s[b];
         byp_data_s   = byp_data_s | (byp_hit_s[b] ? data_in[b*DATA_W +: DATA_W] : {DATA_W{1'b0}});
      end
      if ((BYPASS != 0) && byp_any_s) begin
         rd_data_s = byp_data_s;
         rd_vld_s  = 1'b1;
      end else begin
         rd_data_s = mem_r[rd_addr];
         rd_vld_s  = vld_r[rd_addr];
      end
   end

   generate
      if (REG_RD != 0) begin : g_reg_rd
         // Registered read: one cycle of latency from rd_addr to data_out.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               data_out <= '0;
               rd_valid <= 1'b0;
            end else begin
               data_out <= rd_data_s;
               rd_valid <= rd_vld_s;
            end
         end
      end else begin : g_comb_rd
         assign data_out = rd_data_s;
         assign rd_valid = rd_vld_s;
      end
   endgenerate

endmodule

// File: tb/tb_rf_banked_param.sv
// Self-checking bench for rf_banked_param: three default-geometry instances
// (combinational+forwarding, combinational without forwarding, registered)
// share stimulus and a behavioural model; a wide instance covers 4 banks.
module tb_rf_banked_param;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wr_en;
   logic [5:0]  wr_addr;
   logic [15:0] data_in;
   logic [3:0]  rd_addr;
   logic        clr_req;
   logic [7:0]  d_a, d_b, d_c;
   logic        v_a, v_b, v_c, b_a, b_b, b_c;

   logic [3:0]  wr_en_w;
   logic [11:0] wr_addr_w;
   logic [63:0] data_in_w;
   logic [4:0]  rd_addr_w;
   logic        clr_req_w;
   logic [15:0] d_w;
   logic        v_w, b_w;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   logic [7:0] m_data [16];
   logic       m_valid [16];
   int         sweep_pos;

   // sampled values and expectations for the current cycle
   logic [8:0] pre_a, pre_b, pre_c, post_c, exp_a, exp_b, exp_c;
   logic [2:0] post_busy;
   logic       exp_busy;

   always #5 clk = ~clk;

   rf_banked_param dut_a (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
      .rd_addr(rd_addr), .data_out(d_a), .rd_valid(v_a), .clr_req(clr_req), .clr_busy(b_a));
   rf_banked_param #(.BYPASS(0)) dut_b (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .data_in(data_in), .rd_addr(rd_addr), .data_out(d_b), .rd_valid(v_b), .clr_req(clr_req), .clr_busy(b_b));
   rf_banked_param #(.REG_RD(1)) dut_c (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .data_in(data_in), .rd_addr(rd_addr), .data_out(d_c), .rd_valid(v_c), .clr_req(clr_req), .clr_busy(b_c));
   rf_banked_param #(.DATA_W(16), .DEPTH(32), .N_WR(4)) dut_w (.clk(clk), .rst(rst), .wr_en(wr_en_w),
      .wr_addr(wr_addr_w), .data_in(data_in_w), .rd_addr(rd_addr_w), .data_out(d_w), .rd_valid(v_w),
      .clr_req(clr_req_w), .clr_busy(b_w));

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_data[i]  = 8'h00;
         m_valid[i] = 1'b0;
      end
      sweep_pos = -1;
   endtask

   // Expected {valid,data} at rd_addr; forwarding only when not sweeping.
   function automatic logic [8:0] model_read(input bit byp);
      if (byp && sweep_pos < 0) begin
         for (int b = 0; b < 2; b++) begin
            if (wr_en[b] && (b * 8 + int'(wr_addr[b*3 +: 3])) == int'(rd_addr)) return {1'b1, data_in[b*8 +: 8]};
         end
      end
      return {m_valid[rd_addr], m_data[rd_addr]};
   endfunction

   task automatic model_edge();
      int idx;
      if (sweep_pos >= 0) begin
         m_data[sweep_pos]  = 8'h00;
         m_valid[sweep_pos] = 1'b0;
         sweep_pos++;
         if (sweep_pos == 16) sweep_pos = -1;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (wr_en[b]) begin
               idx = b * 8 + int'(wr_addr[b*3 +: 3]);
               m_data[idx]  = data_in[b*8 +: 8];
               m_valid[idx] = 1'b1;
            end
         end
         if (clr_req) sweep_pos = 0;
      end
   endtask

   // One clock: sample pre-edge outputs, advance the model, sample post-edge.
   task automatic tick();
      #3;
      exp_a = model_read(1'b1);
      exp_b = model_read(1'b0);
      pre_a = {v_a, d_a};
      pre_b = {v_b, d_b};
      pre_c = {v_c, d_c};
      @(posedge clk);
      model_edge();
      #1;
      exp_c     = exp_a;
      post_c    = {v_c, d_c};
      post_busy = {b_a, b_b, b_c};
      exp_busy  = (sweep_pos >= 0);
   endtask

   task automatic idle_inputs();
      wr_en = 2'b00; wr_addr = 6'd0; data_in = 16'h0000; clr_req = 1'b0;
      wr_en_w = 4'h0; wr_addr_w = 12'h000; data_in_w = 64'h0; clr_req_w = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rd_addr = 4'd0; rd_addr_w = 5'd0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({b_a, b_b, b_c, b_w, v_a, v_b, v_c, v_w} !== 8'h00 || {d_a, d_b, d_c, d_w} !== 40'h0) begin
         errors++;
         $display("FAIL reset_state got busy=%b%b%b%b valid=%b%b%b%b data=%h %h %h %h exp all 0",
                  b_a, b_b, b_c, b_w, v_a, v_b, v_c, v_w, d_a, d_b, d_c, d_w);
      end
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic_write();
      wr_en = 2'b11; wr_addr = {3'd3, 3'd3}; data_in = {8'h5A, 8'hA5}; rd_addr = 4'd0;
      tick();
      wr_en = 2'b00; rd_addr = 4'd3;
      tick();
      checks++;
      if (pre_a !== {1'b1, 8'hA5}) begin errors++; $display("FAIL read_entry3 got %h exp %h", pre_a, {1'b1, 8'hA5}); end
      checks++;
      if (post_c !== {1'b1, 8'hA5}) begin errors++; $display("FAIL reg_read_entry3 got %h exp %h", post_c, {1'b1, 8'hA5}); end
      rd_addr = 4'd11;
      tick();
      checks++;
      if (pre_a !== {1'b1, 8'h5A}) begin errors++; $display("FAIL read_entry11 got %h exp %h", pre_a, {1'b1, 8'h5A}); end
   endtask

   task automatic test_bypass();
      wr_en = 2'b10; wr_addr = {3'd3, 3'd0}; data_in = {8'h77, 8'h00}; rd_addr = 4'd11;
      tick();
      checks++;
      if (pre_a !== {1'b1, 8'h77}) begin errors++; $display("FAIL bypass_on got %h exp %h", pre_a, {1'b1, 8'h77}); end
      checks++;
      if (pre_b !== {1'b1, 8'h5A}) begin errors++; $display("FAIL bypass_off got %h exp %h", pre_b, {1'b1, 8'h5A}); end
      wr_en = 2'b00;
      tick();
      checks++;
      if (pre_b !== {1'b1, 8'h77}) begin errors++; $display("FAIL bypass_off_after got %h exp %h", pre_b, {1'b1, 8'h77}); end
   endtask

   task automatic test_reg_read();
      wr_en = 2'b01; wr_addr = {3'd0, 3'd5}; data_in = {8'h00, 8'h3C}; rd_addr = 4'd0;
      tick();
      wr_en = 2'b00; rd_addr = 4'd5;
      tick();
      checks++;
      if (pre_c !== {1'b0, 8'h00}) begin errors++; $display("FAIL reg_read_early got %h exp %h", pre_c, 9'h000); end
      checks++;
      if (post_c !== {1'b1, 8'h3C}) begin errors++; $display("FAIL reg_read_latency got %h exp %h", post_c, {1'b1, 8'h3C}); end
   endtask

   task automatic test_sweep();
      int busy_cycles;
      for (int i = 0; i < 8; i++) begin
         wr_en = 2'b11; wr_addr = {3'(i), 3'(i)}; data_in = 16'($urandom_range(16'h0100, 16'hFFFF)) | 16'h0101;
         tick();
      end
      wr_en = 2'b01; wr_addr = 6'd0; data_in = 16'h00EE; clr_req = 1'b1;
      tick();
      busy_cycles = post_busy[0] ? 1 : 0;
      wr_en = 2'b00; clr_req = 1'b0; rd_addr = 4'd0;
      for (int it = 1; it < 40; it++) begin
         if (it == 5) begin wr_en = 2'b01; wr_addr = 6'd2; data_in = 16'h00FF; clr_req = 1'b1; end
         else begin wr_en = 2'b00; clr_req = 1'b0; end
         tick();
         if (it == 1) begin
            checks++;
            if (pre_a !== {1'b1, 8'hEE}) begin errors++; $display("FAIL write_with_clr_req got %h exp %h", pre_a, {1'b1, 8'hEE}); end
         end
         checks++;
         if (pre_a !== exp_a || post_busy !== {3{exp_busy}}) begin
            errors++;
            $display("FAIL sweep_read it=%0d got %h busy=%b exp %h busy=%b", it, pre_a, post_busy, exp_a, exp_busy);
         end
         rd_addr = 4'($urandom_range(0, 15));
         if (post_busy[0]) busy_cycles++;
         else break;
      end
      wr_en = 2'b00; clr_req = 1'b0;
      checks++;
      if (busy_cycles !== 16) begin errors++; $display("FAIL sweep_busy_len got %0d exp 16", busy_cycles); end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         tick();
         checks++;
         if (pre_a !== 9'h000 || pre_b !== 9'h000) begin
            errors++;
            $display("FAIL after_sweep entry=%0d got %h/%h exp 000", i, pre_a, pre_b);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int busy_cycles;
      wr_en = 2'b10; wr_addr = {3'd7, 3'd0}; data_in = 16'h9100;
      tick();
      wr_en = 2'b00; rd_addr = 4'd15; clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({b_a, b_b, b_c, v_a, v_b, v_c} !== 6'h00 || {d_a, d_b, d_c} !== 24'h0) begin
         errors++;
         $display("FAIL reset_mid_sweep got busy=%b%b%b valid=%b%b%b data=%h %h %h exp all 0",
                  b_a, b_b, b_c, v_a, v_b, v_c, d_a, d_b, d_c);
      end
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      busy_cycles = post_busy[0] ? 1 : 0;
      for (int it = 0; it < 40; it++) begin
         tick();
         if (post_busy[0]) busy_cycles++;
         else break;
      end
      checks++;
      if (busy_cycles !== 16) begin errors++; $display("FAIL resweep_busy_len got %0d exp 16", busy_cycles); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wr_en   = 2'($urandom_range(0, 3));
         wr_addr = 6'($urandom_range(0, 63));
         data_in = 16'($urandom_range(0, 65535));
         rd_addr = 4'($urandom_range(0, 15));
         clr_req = ($urandom_range(0, 39) == 0);
         tick();
         checks++;
         if (pre_a !== exp_a || pre_b !== exp_b || post_c !== exp_c || post_busy !== {3{exp_busy}}) begin
            errors++;
            $display("FAIL random i=%0d got a=%h b=%h c=%h busy=%b exp a=%h b=%h c=%h busy=%b",
                     i, pre_a, pre_b, post_c, post_busy, exp_a, exp_b, exp_c, exp_busy);
         end
      end
      idle_inputs();
   endtask

   task automatic test_wide();
      logic [15:0] wd;
      wd = 16'($urandom_range(1, 65535));
      wr_en_w = 4'b1000; wr_addr_w = {3'd7, 9'd0}; data_in_w = {wd, 48'h0};
      tick();
      wr_en_w = 4'b0000; rd_addr_w = 5'd31;
      #1;
      checks++;
      if ({v_w, d_w} !== {1'b1, wd}) begin errors++; $display("FAIL wide_port3_entry31 got %h exp %h", {v_w, d_w}, {1'b1, wd}); end
      rd_addr_w = 5'd7;
      #1;
      checks++;
      if (v_w !== 1'b0) begin errors++; $display("FAIL wide_entry7_untouched got %b exp 0", v_w); end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_bypass();
      test_reg_read();
      test_sweep();
      test_reset_mid_sweep();
      test_random();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_banked_param.md
RF_BANKED_PARAM -- requirements
Module: rf_banked_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of 2, at least 2*N_WR.
REQ-003 SHALL have parameter N_WR, default 2, number of write ports; power of 2; each port owns one bank of BANK_DEPTH = DEPTH/N_WR contiguous entries.
REQ-004 SHALL have parameter REG_RD, default 0: 0 = asynchronous read, 1 = registered read.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = same-cycle write data forwarded to the read port.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-008 SHALL have port wr_en  input  N_WR  per-bank active-high write enable.
REQ-009 SHALL have port wr_addr  input  N_WR*BANK_AW  per-bank local address, flattened; port b is at bits [b*BANK_AW +: BANK_AW].
REQ-010 SHALL have port data_in  input  N_WR*DATA_W  per-bank write data, flattened the same way.
REQ-011 SHALL have port rd_addr  input  AW  global read address, where AW = log2(DEPTH).
REQ-012 SHALL have port data_out  output  DATA_W  read data.
REQ-013 SHALL have port rd_valid  output  1  set when the addressed entry has been written since its last clear.
REQ-014 SHALL have port clr_req  input  1  one-cycle request to start a sequential clear sweep.
REQ-015 SHALL have port clr_busy  output  1  sweep in progress; writes are dropped while it is high.

Function
REQ-016 SHALL map port b to global entry b*BANK_DEPTH + wr_addr_b; ports never collide.
REQ-017 SHALL, on a rising clk with wr_en[b]=1 and clr_busy=0, write data_in_b to the entry and set its valid bit.
REQ-018 SHALL drop every write issued while clr_busy=1, leaving contents and valid bits unchanged.
REQ-019 SHALL, when REG_RD=0, drive data_out/rd_valid combinationally from rd_addr and the stored state, with zero latency.
REQ-020 SHALL, when REG_RD=1, capture data_out/rd_valid at the rising clk, giving 1-cycle latency.
REQ-021 SHALL, when BYPASS=1, forward data_in_b with rd_valid=1 if an accepted write targets rd_addr in the same cycle; with BYPASS=0, return the pre-write contents.
REQ-022 SHALL implement clear FSM IDLE->SWEEP on clr_req=1 in IDLE; clr_busy SHALL go high on the next cycle.
REQ-023 SHALL, in SWEEP, zero entry cnt and its valid bit each cycle, then increment cnt from 0 up to DEPTH-1, and return to IDLE after clearing DEPTH-1; clr_busy SHALL stay high for exactly DEPTH cycles.
REQ-024 SHALL ignore clr_req while in SWEEP; no restart and no extension.
REQ-025 SHALL accept a write issued in the same cycle as clr_req in IDLE; the sweep later clears it.
REQ-026 SHALL keep reads legal during SWEEP: entries already cleared read data 0 with rd_valid=0, and uncleared entries read their old value.

Reset
REQ-027 SHALL, on rst=0, immediately clear all entries to 0, all valid bits to 0, the FSM to IDLE, cnt to 0, clr_busy to 0, and the registered data_out/rd_valid to 0.
REQ-028 SHALL abort a sweep in progress on reset, with no residual busy state.
REQ-029 SHALL release from reset synchronously to the first rising clk after rst=1.

Structure
REQ-030 SHALL place the FSM state type and the log2 helper (AW and BANK_AW derivation) in shared package rf_pkg.
REQ-031 SHALL implement the sweep FSM and counter as sub-module rf_clear_seq, with outputs clr_busy, clr_en and clr_idx.
REQ-032 SHALL keep storage, bank decode and read/bypass muxing in the top module.

Verification
REQ-033 SHALL cover defaults with REG_RD=0: write 8'hA5 on port0 at addr 3 and 8'h5A on port1 at addr 3 -> entry 3 reads A5, entry 11 reads 5A, rd_valid=1.
REQ-034 SHALL cover BYPASS=1 with REG_RD=0: rd_addr=11 while port1 writes 8'h77 at addr 3 -> data_out=77 in the same cycle; with BYPASS=0 -> old value.
REQ-035 SHALL cover REG_RD=1: write 8'h3C to entry 5, then set rd_addr=5 -> data_out=3C exactly one clock later.
REQ-036 SHALL cover the sweep: fill all 16 entries, pulse clr_req -> clr_busy high for exactly 16 cycles; a write to entry 2 during the sweep is dropped; afterwards every entry reads 0 with rd_valid=0.
REQ-037 SHALL cover reset mid-sweep: rst=0 at sweep cycle 6 -> clr_busy=0 and all outputs 0 immediately; a fresh clr_req after release gives a full 16-cycle sweep.
REQ-038 SHALL cover DATA_W=16, DEPTH=32, N_WR=4: a write on port3 at local addr 7 -> global entry 31 holds the data.
